dmem_arbiter: RTL and testbench

- Two-port arbiter sharing the single-port 16-bit data memory between requester 0 (CPU load/store stage) and requester 1 (debug/DMA loader).
- Grants one access per cycle and drives the memory's write_en/read_en/access_addr/write_data.
- Returns registered read data with a valid strobe.
- Round-robin with bounded burst ownership, so neither requester starves the other.

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_rd_return.sv | 38 +++
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, data
// width and burst counter width.
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;   // burst counter, holds BURST_MAX up to 15

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_rd_return.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_rd_return
// Per-requester read-return register. Captures memory read data on a granted
// read and raises a one-cycle valid strobe on the following cycle. The data
// register holds its value until the next captured read.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   capture  in   granted read this cycle
//   din      in   memory read data (combinational from memory)
//   rdata    out  registered read data
//   rvalid   out  one-cycle strobe, cycle after a granted read
// ---------------------------------------------------------------------------
module dmem_arbiter_rd_return
   import dmem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= capture;
         if (capture) begin
            rdata <= din;
         end
      end
   end

endmodule : dmem_arbiter_rd_return

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port 16-bit data memory between requester 0 (CPU load/store)
// and requester 1 (debug/DMA loader). One access is granted per cycle.
// Ownership is round-robin with a bounded burst: the owner keeps the memory
// while it requests, but hands over after BURST_MAX grants if the other side
// is waiting.
//
// Handshake: a requester raises mx_req with mx_we/mx_addr/mx_wdata stable and
// holds them until mx_gnt is seen high in the same cycle; each cycle with
// mx_gnt high is one completed transfer. Holding mx_req across consecutive
// grants streams back-to-back transfers, with new we/addr/wdata presented
// after each granted cycle. Read data returns on mx_rdata with mx_rvalid high
// for exactly one cycle, the cycle after the granted read.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   m0_req/we/addr/wdata        requester 0 access request
//   m0_gnt                      requester 0 access performed this cycle
//   m0_rdata/m0_rvalid          requester 0 read return
//   m1_*                        same for requester 1
//   mem_write_en/read_en        memory strobes
//   mem_addr/mem_wdata          memory address and write data
//   mem_rdata                   memory read data (combinational)
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [DATA_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_rvalid,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [DATA_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_rvalid,
   output logic              mem_write_en,
   output logic              mem_read_en,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W:0] BURST_LIM = (CNT_W+1)'(BURST_MAX);

   arb_state_t       state, state_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
   logic             last_owner, last_owner_nxt;

   logic             gnt_any;
   logic [CNT_W:0]   cnt_inc;
   logic             burst_done;

   // Grants are suppressed while reset is high so nothing reaches memory.
   assign m0_gnt  = !reset && (state == OWN0) && m0_req;
   assign m1_gnt  = !reset && (state == OWN1) && m1_req;
   assign gnt_any = m0_gnt || m1_gnt;

   // Count including this cycle's grant; burst_done means the owner has used
   // its full burst once this grant completes.
   assign cnt_inc    = {1'b0, burst_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign burst_done = gnt_any && (cnt_inc >= BURST_LIM);

   // ---- state register --------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
      end else begin
         state      <= state_nxt;
         burst_cnt  <= burst_cnt_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   // ---- next-state logic ------------------------------------------------
   always_comb begin
      state_nxt      = state;
      burst_cnt_nxt  = burst_cnt;
      last_owner_nxt = last_owner;

      // Saturating count of grants by the current owner.
      if (gnt_any) begin
         burst_cnt_nxt = (cnt_inc >= BURST_LIM) ? BURST_LIM[CNT_W-1:0]
                                                : cnt_inc[CNT_W-1:0];
      end

      case (state)
         IDLE: begin
            burst_cnt_nxt = '0;
            if (m0_req && m1_req) begin
               // Tie goes to whoever did not own the memory last.
               state_nxt = last_owner ? OWN0 : OWN1;
            end else if (m0_req) begin
               state_nxt = OWN0;
            end else if (m1_req) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (m1_req && (!m0_req || burst_done)) begin
               state_nxt      = OWN1;
               burst_cnt_nxt  = '0;
               last_owner_nxt = 1'b0;
            end else if (!m0_req && !m1_req) begin
               state_nxt      = IDLE;
               burst_cnt_nxt  = '0;
               last_owner_nxt = 1'b0;
            end
         end
         OWN1: begin
            if (m0_req && (!m1_req || burst_done)) begin
               state_nxt      = OWN0;
               burst_cnt_nxt  = '0;
               last_owner_nxt = 1'b1;
            end else if (!m1_req && !m0_req) begin
               state_nxt      = IDLE;
               burst_cnt_nxt  = '0;
               last_owner_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
         end
      endcase
   end

   // ---- output logic: memory port mux -----------------------------------
   always_comb begin
      mem_write_en = 1'b0;
      mem_read_en  = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (m0_gnt) begin
         mem_write_en = m0_we;
         mem_read_en  = !m0_we;
         mem_addr     = m0_addr;
         mem_wdata    = m0_wdata;
      end else if (m1_gnt) begin
         mem_write_en = m1_we;
         mem_read_en  = !m1_we;
         mem_addr     = m1_addr;
         mem_wdata    = m1_wdata;
      end
   end

   // ---- read return -----------------------------------------------------
   dmem_arbiter_rd_return u_rd0 (
      .clk     (clk),
      .reset   (reset),
      .capture (m0_gnt && !m0_we),
      .din     (mem_rdata),
      .rdata   (m0_rdata),
      .rvalid  (m0_rvalid)
   );

   dmem_arbiter_rd_return u_rd1 (
      .clk     (clk),
      .reset   (reset),
      .capture (m1_gnt && !m1_we),
      .din     (mem_rdata),
      .rdata   (m1_rdata),
      .rvalid  (m1_rvalid)
   );

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with an 8-word memory model (low 3 address
// bits decoded, write at the clock edge, combinational read). Inputs change on
// the falling edge; outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [15:0] m0_rdata, m1_rdata;
   logic        mem_write_en, mem_read_en;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_word;
   logic        exp0, prev0;

   // ---- clock ------------------------------------------------------------
   always #5 clk = ~clk;

   // ---- memory model -----------------------------------------------------
   logic [15:0] mem_model [0:7] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                                    16'hA004, 16'hA005, 16'hA006, 16'hA007};

   always @(posedge clk) begin
      if (mem_write_en) mem_model[mem_addr[2:0]] <= mem_wdata;
   end
   assign mem_rdata = mem_model[mem_addr[2:0]];

   dmem_arbiter #(.BURST_MAX(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .m0_req       (m0_req),
      .m0_we        (m0_we),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_gnt       (m0_gnt),
      .m0_rdata     (m0_rdata),
      .m0_rvalid    (m0_rvalid),
      .m1_req       (m1_req),
      .m1_we        (m1_we),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_gnt       (m1_gnt),
      .m1_rdata     (m1_rdata),
      .m1_rvalid    (m1_rvalid),
      .mem_write_en (mem_write_en),
      .mem_read_en  (mem_read_en),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // ---- checker ------------------------------------------------------------
   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---- driver tasks -------------------------------------------------------
   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [15:0] word_at(input int a);
      // Address 3 holds BEEF after the first write test; others are preset.
      if (a % 8 == 3) return 16'hBEEF;
      return 16'hA000 + 16'(a % 8);
   endfunction

   // ---- watchdog -----------------------------------------------------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

   // ---- stimulus -----------------------------------------------------------
   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_gnt0",   {15'd0, m0_gnt}, 16'd0);
      check("rst_gnt1",   {15'd0, m1_gnt}, 16'd0);
      check("rst_rvalid", {14'd0, m0_rvalid, m1_rvalid}, 16'd0);
      check("rst_rdata0", m0_rdata, 16'h0000);
      check("rst_rdata1", m1_rdata, 16'h0000);
      check("rst_mem_en", {14'd0, mem_write_en, mem_read_en}, 16'd0);

      // -- m0 write 3 = BEEF, then read 3 ----------------------------------
      @(negedge clk);
      m0_req = 1; m0_we = 1; m0_addr = 16'd3; m0_wdata = 16'hBEEF;
      #1 check("wr_idle_nogrant", {15'd0, m0_gnt}, 16'd0);
      @(negedge clk); #1;
      check("wr_gnt",    {15'd0, m0_gnt}, 16'd1);
      check("wr_we",     {15'd0, mem_write_en}, 16'd1);
      check("wr_addr",   mem_addr, 16'd3);
      check("wr_wdata",  mem_wdata, 16'hBEEF);
      @(negedge clk);
      m0_we = 0;
      #1;
      check("rd_gnt",    {15'd0, m0_gnt}, 16'd1);
      check("rd_re",     {14'd0, mem_write_en, mem_read_en}, 16'd1);
      @(negedge clk);
      m0_req = 0;
      #1;
      check("rd_rvalid0", {15'd0, m0_rvalid}, 16'd1);
      check("rd_rdata0",  m0_rdata, 16'hBEEF);
      check("rd_rvalid1", {15'd0, m1_rvalid}, 16'd0);
      @(negedge clk); #1;
      check("rd_pulse_end", {15'd0, m0_rvalid}, 16'd0);
      check("rd_hold",      m0_rdata, 16'hBEEF);

      // -- tie from IDLE after reset, then burst round-robin ---------------
      do_reset();
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 16'd1;
      m1_req = 1; m1_we = 0; m1_addr = 16'd2;
      #1 check("tie_idle", {14'd0, m0_gnt, m1_gnt}, 16'd0);
      prev0 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); #1;
         exp0 = ((i / 4) % 2) == 0;
         check("rr_gnt0", {15'd0, m0_gnt}, {15'd0, exp0});
         check("rr_gnt1", {15'd0, m1_gnt}, {15'd0, !exp0});
         if (i > 0) begin
            check("rr_rvalid0", {15'd0, m0_rvalid}, {15'd0, prev0});
            check("rr_rvalid1", {15'd0, m1_rvalid}, {15'd0, !prev0});
            if (m0_rvalid) check("rr_rdata0", m0_rdata, 16'hA001);
            if (m1_rvalid) check("rr_rdata1", m1_rdata, 16'hA002);
         end
         prev0 = exp0;
      end
      @(negedge clk);
      m0_req = 0; m1_req = 0;
      #1;
      check("rr_last_rvalid1", {15'd0, m1_rvalid}, 16'd1);
      check("rr_last_rdata1",  m1_rdata, 16'hA002);
      check("rr_drop_nogrant", {14'd0, m0_gnt, m1_gnt}, 16'd0);

      // -- m1 streams 10 reads alone ----------------------------------------
      @(negedge clk);
      m1_req = 1; m1_we = 0; m1_addr = 16'd0;
      #1 check("strm_idle", {15'd0, m1_gnt}, 16'd0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         m1_addr = 16'(c);
         #1;
         check("strm_gnt1", {14'd0, m0_gnt, m1_gnt}, 16'd1);
         check("strm_rvalid", {15'd0, m1_rvalid}, {15'd0, (c > 0)});
         if (m1_rvalid) begin
            exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
            check("strm_rdata", m1_rdata, exp_word);
         end
         if (m1_gnt) exp_q.push_back(word_at(c));
      end
      @(negedge clk);
      m1_req = 0;
      #1;
      check("strm_last_rvalid", {15'd0, m1_rvalid}, 16'd1);
      exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
      check("strm_last_rdata", m1_rdata, exp_word);
      check("strm_q_empty", 16'(exp_q.size()), 16'd0);

      // -- m1 write 5 = 1234, then m0 read 5 --------------------------------
      @(negedge clk);
      m1_req = 1; m1_we = 1; m1_addr = 16'd5; m1_wdata = 16'h1234;
      #1 check("w5_idle", {15'd0, m1_gnt}, 16'd0);
      @(negedge clk); #1;
      check("w5_gnt1", {15'd0, m1_gnt}, 16'd1);
      check("w5_we",   {15'd0, mem_write_en}, 16'd1);
      check("w5_addr", mem_addr, 16'd5);
      @(negedge clk);
      m1_req = 0;
      m0_req = 1; m0_we = 0; m0_addr = 16'd5;
      #1 check("w5_handover", {14'd0, m0_gnt, m1_gnt}, 16'd0);
      @(negedge clk); #1;
      check("r5_gnt0", {15'd0, m0_gnt}, 16'd1);
      @(negedge clk);
      m0_req = 0;
      #1;
      check("r5_rvalid0", {15'd0, m0_rvalid}, 16'd1);
      check("r5_rdata0",  m0_rdata, 16'h1234);

      // -- reset while OWN1 with a read just granted ------------------------
      @(negedge clk);
      m1_req = 1; m1_we = 0; m1_addr = 16'd2;
      @(negedge clk); #1;
      check("mr_gnt1", {15'd0, m1_gnt}, 16'd1);
      @(negedge clk);
      reset = 1'b1;
      m0_req = 1; m0_we = 0; m0_addr = 16'd1;
      #1;
      check("mr_rst_gnt",    {14'd0, m0_gnt, m1_gnt}, 16'd0);
      check("mr_rst_mem_en", {14'd0, mem_write_en, mem_read_en}, 16'd0);
      check("mr_rst_pulse",  {15'd0, m1_rvalid}, 16'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mr_post_rvalid", {15'd0, m1_rvalid}, 16'd0);
      check("mr_post_rdata",  m1_rdata, 16'h0000);
      check("mr_post_gnt",    {14'd0, m0_gnt, m1_gnt}, 16'd0);
      @(negedge clk); #1;
      check("mr_first_gnt", {14'd0, m0_gnt, m1_gnt}, 16'd2);

      idle_inputs();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dmem_arbiter
